// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcodes, FSM
// states and the encodings of the multi-bit datapath select fields.
// Imported by mc_control_unit and mc_mem_wait.
package mc_pkg;

  // Primary opcodes (IR[31:26]) handled by the control unit.
  localparam logic [5:0] OP_RFORMAT = 6'b000000;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_J       = 6'b000010;

  // FSM states. Codes 13..15 are unused and recover to S_FETCH.
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_R_WB      = 4'd3,
    S_EXEC_ADDI = 4'd4,
    S_EXEC_ANDI = 4'd5,
    S_I_WB      = 4'd6,
    S_MEM_ADDR  = 4'd7,
    S_MEM_RD    = 4'd8,
    S_LW_WB     = 4'd9,
    S_MEM_WR    = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12
  } state_e;

  // alu_op
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_AND   = 2'b11;

  // alu_src_b
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // pc_source
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // reg_dst
  localparam logic [1:0] REGDST_RT  = 2'b00;
  localparam logic [1:0] REGDST_RD  = 2'b01;
  localparam logic [1:0] REGDST_R31 = 2'b10;

  // mem_to_reg
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // True for every opcode the FSM knows how to sequence.
  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RFORMAT, OP_ADDI, OP_ANDI, OP_LW,
      OP_SW, OP_BEQ, OP_BNE, OP_J: return 1'b1;
      default:                     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_mem_wait.sv
// Memory handshake wait counter with timeout compare.
// Latency: timeout is combinational from the registered count (no input path).
// Backpressure: counts every cycle 'waiting' is high and 'clear' is low; saturates.
// Ports: clk, reset (sync, active-high), clear (zero the count, wins over
//        waiting), waiting (in a memory wait state), timeout (count reached limit).
module mc_mem_wait import mc_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic waiting,
  output logic timeout
);

  localparam logic             TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt;

  // Saturate rather than wrap so a disabled timeout can never alias back to 0.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (waiting && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Depends only on registered state, so the abort never loops through mem_ready.
  assign timeout = TO_EN && waiting && (cnt == LIMIT);

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/writeback over one shared memory port.
// Latency: R/ADDI/ANDI/SW 4, LW 5, BEQ/BNE/J 3 cycles, plus one per mem_ready-low wait cycle.
// Backpressure: mem_read/mem_write held until mem_ready; aborts to FETCH after TIMEOUT_CYCLES waits.
// Ports: clk, reset (sync, active-high); opcode, zero, mem_ready in;
//        memory controls mem_read/mem_write/i_or_d/ir_write; PC controls pc_write/
//        pc_write_cond/branch_taken/pc_source; ALU selects alu_src_a/alu_src_b/alu_op;
//        regfile reg_write/reg_dst/mem_to_reg; status pulses illegal_op/mem_timeout/instr_done.
module mc_control_unit import mc_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_taken,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic       instr_done
);

  state_e state;
  state_e state_nxt;

  logic in_wait;
  logic timeout;
  logic wait_clr;
  logic req_ok;
  logic acc_done;

  // ---------------------------------------------------------------------------
  // Wait counter: cleared on every state change (so each wait state starts at
  // zero), on a completed access and on abort.
  // ---------------------------------------------------------------------------
  assign in_wait  = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign wait_clr = mem_ready || timeout || (state_nxt != state);

  mc_mem_wait #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_mem_wait (
    .clk     (clk),
    .reset   (reset),
    .clear   (wait_clr),
    .waiting (in_wait),
    .timeout (timeout)
  );

  // Requests are suppressed while aborting and during a reset cycle, so a
  // reset that lands mid-access never issues or completes that access.
  assign req_ok   = !timeout && !reset;
  assign acc_done = mem_ready && req_ok;

  // Branch condition is the one combinational output; the datapath ANDs it
  // with pc_write_cond.
  assign branch_taken = (opcode == OP_BEQ) ? zero  :
                        (opcode == OP_BNE) ? !zero : 1'b0;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: begin
        if (timeout)        state_nxt = S_FETCH;
        else if (mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_RFORMAT:    state_nxt = S_EXEC_R;
          OP_ADDI:       state_nxt = S_EXEC_ADDI;
          OP_ANDI:       state_nxt = S_EXEC_ANDI;
          OP_LW, OP_SW:  state_nxt = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_nxt = S_BRANCH;
          OP_J:          state_nxt = S_JUMP;
          default:       state_nxt = S_FETCH;
        endcase
      end
      S_EXEC_R:    state_nxt = S_R_WB;
      S_EXEC_ADDI: state_nxt = S_I_WB;
      S_EXEC_ANDI: state_nxt = S_I_WB;
      S_MEM_ADDR:  state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (timeout)        state_nxt = S_FETCH;
        else if (mem_ready) state_nxt = S_LW_WB;
      end
      S_MEM_WR: begin
        if (timeout || mem_ready) state_nxt = S_FETCH;
      end
      S_R_WB, S_I_WB, S_LW_WB,
      S_BRANCH, S_JUMP: state_nxt = S_FETCH;
      default:          state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode (state register; handshake terms qualified by mem_ready)
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCSRC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    reg_write     = 1'b0;
    reg_dst       = REGDST_RT;
    mem_to_reg    = M2R_ALUOUT;
    illegal_op    = 1'b0;
    mem_timeout   = 1'b0;
    instr_done    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read    = req_ok;
        alu_src_b   = SRCB_FOUR;
        ir_write    = acc_done;
        pc_write    = acc_done;
        mem_timeout = timeout && !reset;
      end
      S_DECODE: begin
        // Branch target precomputed into ALUOut while the opcode is decoded.
        alu_src_b  = SRCB_IMM_SH;
        illegal_op = !op_supported(opcode);
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = REGDST_RD;
        instr_done = 1'b1;
      end
      S_EXEC_ADDI: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_EXEC_ANDI: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_AND;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_read    = req_ok;
        i_or_d      = 1'b1;
        mem_timeout = timeout && !reset;
      end
      S_LW_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_MDR;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write   = req_ok;
        i_or_d      = 1'b1;
        mem_timeout = timeout && !reset;
        instr_done  = acc_done;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        // PC already holds PC+4 here, which is the link value for r31.
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        reg_write  = 1'b1;
        reg_dst    = REGDST_R31;
        mem_to_reg = M2R_PC;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: per-instruction cycle plans built from opcode,
// memory wait counts and the timeout limit, checked cycle by cycle.
module tb_mc_control_unit;

  localparam int T = 4;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_taken;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       illegal_op;
    logic       mem_timeout;
    logic       instr_done;
  } ov_t;

  typedef struct {
    ov_t        o;
    logic [5:0] op;
    logic       z;
    logic       rdy;
    string      tag;
  } cyc_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, branch_taken;
  logic [1:0] pc_source, alu_src_b, alu_op, reg_dst, mem_to_reg;
  logic       alu_src_a, reg_write, illegal_op, mem_timeout, instr_done;
  ov_t        obs;

  int   total = 0;
  int   bad   = 0;
  cyc_t q[$];

  always #5 clk = ~clk;

  mc_control_unit #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_taken(branch_taken),
    .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout), .instr_done(instr_done)
  );

  assign obs = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, branch_taken,
                pc_source, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
                illegal_op, mem_timeout, instr_done};

  function automatic bit is_legal(input logic [5:0] op);
    return op == 6'h00 || op == 6'h08 || op == 6'h0C || op == 6'h23 ||
           op == 6'h2B || op == 6'h04 || op == 6'h05 || op == 6'h02;
  endfunction

  // Expected control word for one cycle of a named step of an instruction.
  function automatic ov_t exp_phase(input string ph, input logic bt, input logic rdy,
                                    input logic ab, input logic ill);
    ov_t o;
    o = '0;
    o.branch_taken = bt;
    if (ph == "fetch") begin
      o.mem_read = !ab; o.alu_src_b = 2'b01; o.mem_timeout = ab;
      o.ir_write = rdy && !ab; o.pc_write = rdy && !ab;
    end else if (ph == "decode") begin
      o.alu_src_b = 2'b11; o.illegal_op = ill;
    end else if (ph == "exec_r") begin
      o.alu_src_a = 1'b1; o.alu_op = 2'b10;
    end else if (ph == "r_wb") begin
      o.reg_write = 1'b1; o.reg_dst = 2'b01; o.instr_done = 1'b1;
    end else if (ph == "addi" || ph == "maddr") begin
      o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
    end else if (ph == "andi") begin
      o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = 2'b11;
    end else if (ph == "i_wb") begin
      o.reg_write = 1'b1; o.instr_done = 1'b1;
    end else if (ph == "mrd") begin
      o.mem_read = !ab; o.i_or_d = 1'b1; o.mem_timeout = ab;
    end else if (ph == "lw_wb") begin
      o.reg_write = 1'b1; o.mem_to_reg = 2'b01; o.instr_done = 1'b1;
    end else if (ph == "mwr") begin
      o.mem_write = !ab; o.i_or_d = 1'b1; o.mem_timeout = ab; o.instr_done = rdy && !ab;
    end else if (ph == "branch") begin
      o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_write_cond = 1'b1;
      o.pc_source = 2'b01; o.instr_done = 1'b1;
    end else if (ph == "jump") begin
      o.pc_write = 1'b1; o.pc_source = 2'b10; o.reg_write = 1'b1;
      o.reg_dst = 2'b10; o.mem_to_reg = 2'b10; o.instr_done = 1'b1;
    end
    return o;
  endfunction

  task automatic push(input string ph, input logic [5:0] op, input logic z,
                      input logic rdy, input logic ab, input logic ill);
    cyc_t c;
    logic bt;
    bt    = (op == 6'h04) ? z : (op == 6'h05) ? !z : 1'b0;
    c.o   = exp_phase(ph, bt, rdy, ab, ill);
    c.op  = op;
    c.z   = z;
    c.rdy = rdy;
    c.tag = ph;
    q.push_back(c);
  endtask

  // A memory access with w low-ready cycles; w >= T means the access aborts.
  task automatic access(input string ph, input logic [5:0] op, input logic z,
                        input int w, output bit ab);
    ab = (w >= T);
    for (int i = 0; i < (ab ? T : w); i++) push(ph, op, z, 1'b0, 1'b0, 1'b0);
    push(ph, op, z, !ab, ab, 1'b0);
  endtask

  task automatic plan(input logic [5:0] op, input logic z, input int fw, input int mw);
    bit ab;
    access("fetch", op, z, fw, ab);
    if (ab) return;
    push("decode", op, z, 1'($urandom), 1'b0, !is_legal(op));
    case (op)
      6'h00: begin push("exec_r", op, z, 1'($urandom), 0, 0); push("r_wb", op, z, 1'($urandom), 0, 0); end
      6'h08: begin push("addi", op, z, 1'($urandom), 0, 0); push("i_wb", op, z, 1'($urandom), 0, 0); end
      6'h0C: begin push("andi", op, z, 1'($urandom), 0, 0); push("i_wb", op, z, 1'($urandom), 0, 0); end
      6'h23: begin
        push("maddr", op, z, 1'($urandom), 0, 0);
        access("mrd", op, z, mw, ab);
        if (!ab) push("lw_wb", op, z, 1'($urandom), 0, 0);
      end
      6'h2B: begin
        push("maddr", op, z, 1'($urandom), 0, 0);
        access("mwr", op, z, mw, ab);
      end
      6'h04, 6'h05: push("branch", op, z, 1'($urandom), 0, 0);
      6'h02:        push("jump", op, z, 1'($urandom), 0, 0);
      default: ;
    endcase
  endtask

  task automatic run();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      reset     = 1'b0;
      opcode    = c.op;
      zero      = c.z;
      mem_ready = c.rdy;
      #1;
      total++;
      assert (obs === c.o) else begin
        bad++;
        $error("FAIL %s op=%h: got %h want %h", c.tag, c.op, obs, c.o);
      end
    end
  endtask

  initial begin
    logic [5:0] legal [8];
    logic [5:0] op;
    legal = '{6'h00, 6'h08, 6'h0C, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
    reset = 1'b1; mem_ready = 1'b1; opcode = 6'h00; zero = 1'b0;

    // Reset held 3 cycles with memory ready: no request, no status pulses.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total++;
      assert ({obs.mem_read, obs.mem_write, obs.ir_write, obs.pc_write,
               obs.mem_timeout, obs.illegal_op, obs.instr_done} === 7'b0) else begin
        bad++;
        $error("FAIL reset_quiet: got %b want 0000000", {obs.mem_read, obs.mem_write,
               obs.ir_write, obs.pc_write, obs.mem_timeout, obs.illegal_op, obs.instr_done});
      end
    end

    // Directed: ADD, LW with 3 waits, BNE/BEQ with zero=0, J, illegal,
    // ADDI/ANDI with fetch waits, SW timeout, fetch timeout.
    plan(6'h00, 1'b0, 0, 0); run();
    plan(6'h23, 1'b1, 0, 3); run();
    plan(6'h05, 1'b0, 0, 0); run();
    plan(6'h04, 1'b0, 0, 0); run();
    plan(6'h02, 1'b1, 0, 0); run();
    plan(6'h3F, 1'b0, 0, 0); run();
    plan(6'h08, 1'b0, 2, 0); run();
    plan(6'h0C, 1'b1, 3, 0); run();
    plan(6'h2B, 1'b0, 0, 9); run();
    plan(6'h00, 1'b0, 6, 0); run();
    plan(6'h2B, 1'b1, 0, 0); run();

    // Reset during MEM_WR abandons the store; the counter restarts from zero.
    push("fetch", 6'h2B, 1'b0, 1'b1, 0, 0);
    push("decode", 6'h2B, 1'b0, 1'b0, 0, 0);
    push("maddr", 6'h2B, 1'b0, 1'b0, 0, 0);
    push("mwr", 6'h2B, 1'b0, 1'b0, 0, 0);
    push("mwr", 6'h2B, 1'b0, 1'b0, 0, 0);
    run();
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b0;
    #1;
    total++;
    assert ({obs.mem_write, obs.mem_read, obs.instr_done} === 3'b000) else begin
      bad++;
      $error("FAIL rst_mid_access: got %b want 000", {obs.mem_write, obs.mem_read, obs.instr_done});
    end
    plan(6'h23, 1'b0, 0, 3); run();

    // Random instruction stream.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) < 8) begin
        op = legal[$urandom_range(0, 7)];
      end else begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end
      plan(op, 1'($urandom),
           ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0,
           ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0);
      run();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multicycle control FSM for the MIPS datapath: sequences fetch, decode, execute, memory and writeback over several clocks.
- Replaces the single-cycle decoder when instruction and data share one memory port.
- Supports the same opcode set: R-format, ADDI, ANDI, LW, SW, BEQ, BNE, J. J also writes the return address to r31.
- Memory accesses use a req/ready handshake with a timeout.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles to wait for mem_ready before aborting. 0 disables the timeout.
- CNT_W, 8: width of the wait counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26], valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the access this cycle
- mem_read  out  1  read request; held until ready
- mem_write  out  1  write request; held until ready
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR from memory data
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  conditional PC load; datapath gates it with branch_taken
- branch_taken  out  1  BEQ: zero; BNE: !zero; otherwise 0
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- alu_src_a  out  1  0 = PC, 1 = reg A
- alu_src_b  out  2  00 reg B, 01 const 4, 10 sext imm, 11 sext imm<<2
- alu_op  out  2  00 add, 01 sub, 10 funct, 11 and
- reg_write  out  1  register-file write enable
- reg_dst  out  2  00 rt, 01 rd, 10 r31
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- mem_timeout  out  1  one-cycle pulse on handshake abort
- instr_done  out  1  one-cycle pulse in the final state of each instruction

Interface decision: one clock, clk; reset is synchronous and active-high, named reset.

Behaviour:
- Moore FSM: outputs are decoded from the state register only. branch_taken is the one exception and is combinational from zero and opcode.
- Any output not listed for a state is 0.
- Reset: state = FETCH, wait counter = 0, and every output is 0 except FETCH's. No memory request is issued during the reset cycle itself. Reset asserted mid-access abandons the access; FSM is in FETCH the next cycle.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=1 and pc_write=1 only when mem_ready=1, which also moves to DECODE.
  - Otherwise stay in FETCH and count.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precompute branch target). Next state by opcode:
  - R-format -> EXEC_R
  - ADDI -> EXEC_ADDI
  - ANDI -> EXEC_ANDI
  - LW or SW -> MEM_ADDR
  - BEQ or BNE -> BRANCH
  - J -> JUMP
  - anything else -> FETCH with illegal_op=1
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB.
- R_WB: reg_write=1, reg_dst=01, mem_to_reg=00, instr_done=1 -> FETCH.
- EXEC_ADDI: alu_src_a=1, alu_src_b=10, alu_op=00 -> I_WB.
- EXEC_ANDI: alu_src_a=1, alu_src_b=10, alu_op=11 -> I_WB.
- I_WB: reg_write=1, reg_dst=00, mem_to_reg=00, instr_done=1 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00 -> MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_read=1, i_or_d=1; on mem_ready -> LW_WB.
- LW_WB: reg_write=1, reg_dst=00, mem_to_reg=01, instr_done=1 -> FETCH.
- MEM_WR: mem_write=1, i_or_d=1; on mem_ready -> FETCH with instr_done=1.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1 -> FETCH.
- JUMP: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10, instr_done=1 -> FETCH. The PC already holds PC+4 at this point, so it is the link value.
- Latency with mem_ready already high:
  - R, ADDI, ANDI: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - BEQ, BNE, J: 3 cycles
- Each wait cycle in FETCH, MEM_RD or MEM_WR adds one cycle.
- Wait counter:
  - Cleared on entry to any wait state and on mem_ready.
  - Increments on each wait cycle with mem_ready=0.
  - When TIMEOUT_CYCLES != 0 and the count reaches TIMEOUT_CYCLES: mem_timeout=1 for one cycle, requests drop, FSM -> FETCH.
  - No state update on abort (no ir_write, pc_write or reg_write).
  - The counter saturates; it never wraps.
- mem_read and mem_write are never high together.
- Unreachable state encodings recover to FETCH.

Decomposition:
- Shared package mc_pkg holds:
  - opcode constants (RFORMAT, ADDI, ANDI, LW, SW, BEQ, BNE, J)
  - state enum
  - encodings for alu_op, alu_src_b, pc_source, reg_dst and mem_to_reg
- One sub-module, mc_mem_wait: the wait counter plus timeout compare. Inputs: clear, waiting. Outputs: timeout.

Test Plan:
- Reset held 3 cycles, then released with mem_ready=1 -> first cycle after release is FETCH: mem_read=1, pc_write=1, ir_write=1; illegal_op=0, mem_timeout=0.
- ADD (opcode 000000), mem_ready=1 -> states FETCH, DECODE, EXEC_R, R_WB; reg_write=1 and reg_dst=01 in cycle 4; instr_done in cycle 4.
- LW (100011) with mem_ready low 3 cycles in MEM_RD -> mem_read held 3 extra cycles, i_or_d=1; LW_WB has mem_to_reg=01; total 8 cycles.
- BNE (000101) with zero=0, then BEQ (000100) with zero=0 -> branch_taken=1 for BNE, 0 for BEQ; pc_write_cond=1 and pc_source=01 in both; 3 cycles each.
- J (000010) -> JUMP: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10. Opcode 111111 -> illegal_op pulse in DECODE, next state FETCH, no reg_write.
- TIMEOUT_CYCLES=4, SW with mem_ready held 0 -> mem_timeout pulses after 4 wait cycles; mem_write drops; FSM in FETCH; no instr_done. Reset asserted during MEM_WR -> FETCH next cycle, mem_write=0.
